// File: rtl/btn_irq_ctrl.sv
// Push-button interrupt source: synchronizes and debounces a raw button, counts
// presses, and raises a level interrupt with ack handshake and post-ack holdoff.
module btn_irq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned HOLDOFF_CYCLES  = 100000
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       btn_i,
  input  logic       irq_en_i,
  input  logic       irq_ack_i,
  input  logic       ovf_clr_i,
  output logic       irq_req_o,
  output logic       btn_level_o,
  output logic [7:0] press_cnt_o,
  output logic       overflow_o
);

  localparam int unsigned CW = 20;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HOLDOFF
  } state_e;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press;
  logic [7:0]    press_cnt_q;
  logic          overflow_q;
  state_e        state_q;
  logic [CW-1:0] hold_q;
  logic          irq_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Level flips on the edge the run of disagreeing samples would reach DEBOUNCE_CYCLES.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      db_cnt_q     <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign press = level_q & ~level_prev_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      press_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (press) begin
        press_cnt_q <= press_cnt_q + 8'd1;
      end
      // A dropped press wins over a coincident clear.
      if (press && (state_q != IDLE)) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press && irq_en_i) begin
            state_q <= PEND;
            irq_q   <= 1'b1;
          end
        end
        PEND: begin
          if (irq_ack_i) begin
            state_q <= HOLDOFF;
            hold_q  <= HOLD_LOAD;
            irq_q   <= 1'b0;
          end else if (!irq_en_i) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        end
        HOLDOFF: begin
          if (hold_q == '0) begin
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o   = irq_q;
  assign btn_level_o = level_q;
  assign press_cnt_o = press_cnt_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Directed and randomized checks of btn_irq_ctrl against a cycle-level behavioural model.
module tb_btn_irq_ctrl;

  localparam int DB = 4;
  localparam int HO = 8;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       btn, en, ack, clr;
  logic       irq, lvl, ovf;
  logic [7:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  bit m_s1, m_s2, m_lvl, m_prev, m_pend, m_ovf;
  int m_run, m_hold, m_cnt;

  btn_irq_ctrl #(.DEBOUNCE_CYCLES(DB), .HOLDOFF_CYCLES(HO)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .btn_i       (btn),
    .irq_en_i    (en),
    .irq_ack_i   (ack),
    .ovf_clr_i   (clr),
    .irq_req_o   (irq),
    .btn_level_o (lvl),
    .press_cnt_o (cnt),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0; m_pend = 0; m_ovf = 0;
    m_run = 0; m_hold = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit p, busy;
    p = m_lvl && !m_prev;
    m_prev = m_lvl;
    if (m_s2 != m_lvl) begin
      m_run++;
      if (m_run == DB) begin
        m_lvl = !m_lvl;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
    busy = m_pend || (m_hold > 0);
    if (p) m_cnt = (m_cnt + 1) % 256;
    if (p && busy) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (m_pend) begin
      if (ack) begin
        m_pend = 0;
        m_hold = HO;
      end else if (!en) begin
        m_pend = 0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (p && en) begin
      m_pend = 1;
    end
  endtask

  task automatic check_model();
    check("lvl", {7'd0, lvl}, {7'd0, m_lvl});
    check("irq", {7'd0, irq}, {7'd0, m_pend});
    check("cnt", cnt, 8'(m_cnt));
    check("ovf", {7'd0, ovf}, {7'd0, m_ovf});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int old_cnt;
    bit seen;
    int guard;
    int run;

    arst_n = 1'b0; btn = 0; en = 1; ack = 0; clr = 0;
    model_reset();
    #12;
    check("rst_irq", {7'd0, irq}, 8'd0);
    check("rst_lvl", {7'd0, lvl}, 8'd0);
    check("rst_cnt", cnt, 8'd0);
    check("rst_ovf", {7'd0, ovf}, 8'd0);
    @(negedge clk); arst_n = 1'b1;

    // Clean press: level at edge 6, request at edge 7.
    @(negedge clk); btn = 1;
    steps(5);
    check("clean_lvl_e5", {7'd0, lvl}, 8'd0);
    step();
    check("clean_lvl_e6", {7'd0, lvl}, 8'd1);
    check("clean_irq_e6", {7'd0, irq}, 8'd0);
    step();
    check("clean_irq_e7", {7'd0, irq}, 8'd1);
    check("clean_cnt", cnt, 8'd1);

    // Release while pending, start second press, then ack into holdoff.
    btn = 0;
    steps(8);
    check("pend_hold_irq", {7'd0, irq}, 8'd1);
    btn = 1;
    step();
    ack = 1;
    step();
    ack = 0;
    check("ack_irq_drop", {7'd0, irq}, 8'd0);
    steps(20);
    check("holdoff_irq", {7'd0, irq}, 8'd0);
    check("holdoff_ovf", {7'd0, ovf}, 8'd1);
    check("holdoff_cnt", cnt, 8'd2);

    // Bounce shorter than the debounce window.
    btn = 0;
    steps(10);
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn = ~btn;
      step();
    end
    btn = 0;
    steps(10);
    check("bounce_lvl", {7'd0, lvl}, 8'd0);
    check("bounce_cnt", cnt, 8'd2);
    check("bounce_irq", {7'd0, irq}, 8'd0);

    clr = 1;
    step();
    clr = 0;
    check("ovf_clear", {7'd0, ovf}, 8'd0);

    // Disabled press, then disable while pending.
    en = 0; btn = 1;
    steps(10);
    check("dis_cnt", cnt, 8'd3);
    check("dis_irq", {7'd0, irq}, 8'd0);
    check("dis_ovf", {7'd0, ovf}, 8'd0);
    btn = 0;
    steps(10);
    en = 1; btn = 1;
    steps(8);
    check("en_irq", {7'd0, irq}, 8'd1);
    en = 0;
    step();
    check("dis_pend_irq", {7'd0, irq}, 8'd0);
    btn = 0;
    steps(10);

    // Randomized traffic.
    run = 0;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        btn = ~btn;
        run = int'($urandom_range(1, 12));
      end
      run--;
      en  = ($urandom_range(0, 9) != 0);
      ack = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step();
    end
    en = 0; ack = 0; clr = 0; btn = 0;
    steps(20);

    // Press counter wrap with interrupts disabled.
    guard = 0;
    while (m_cnt != 255 && guard < 300) begin
      btn = 1; steps(8);
      btn = 0; steps(8);
      guard++;
    end
    if (m_cnt != 255) begin
      n_cmp++; n_bad++;
      $error("FAIL wrap_setup observed=%0d expected=255", m_cnt);
    end
    en = 1; btn = 1;
    steps(8);
    check("wrap_cnt", cnt, 8'd0);
    check("wrap_irq", {7'd0, irq}, 8'd1);
    btn = 0;
    steps(8);

    // Overflowing press coincident with clear.
    clr = 1; btn = 1;
    old_cnt = m_cnt;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (m_cnt != old_cnt) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $error("FAIL ovf_press_timeout observed=0 expected=1");
    end
    check("ovf_set_wins", {7'd0, ovf}, 8'd1);
    clr = 0;

    // Reset while pending, button held through release.
    check("pre_rst_irq", {7'd0, irq}, 8'd1);
    #3 arst_n = 1'b0;
    #1;
    model_reset();
    check("arst_irq", {7'd0, irq}, 8'd0);
    check("arst_lvl", {7'd0, lvl}, 8'd0);
    check("arst_cnt", cnt, 8'd0);
    check("arst_ovf", {7'd0, ovf}, 8'd0);
    @(negedge clk); arst_n = 1'b1;
    steps(6);
    check("held_lvl_e6", {7'd0, lvl}, 8'd1);
    check("held_cnt_e6", cnt, 8'd0);
    step();
    check("held_cnt_e7", cnt, 8'd1);
    check("held_irq_e7", {7'd0, irq}, 8'd1);
    steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_irq_ctrl.md
BTN_IRQ_CTRL -- requirements
Module: btn_irq_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, meaning consecutive stable cycles required to accept a new button level; legal range 1..2^20-1.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 100000, meaning lockout cycles after each acknowledged interrupt; legal range 1..2^20-1.
REQ-003 SHALL have port clk_i, input, 1, single clock for the whole block.
REQ-004 SHALL have port arst_n_i, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port btn_i, input, 1, raw button, asynchronous to clk_i, bouncy.
REQ-006 SHALL have port irq_en_i, input, 1, interrupt enable from the core.
REQ-007 SHALL have port irq_ack_i, input, 1, interrupt acknowledge from the core.
REQ-008 SHALL have port ovf_clr_i, input, 1, clears overflow_o.
REQ-009 SHALL have port irq_req_o, output, 1, level interrupt request to the core irq_btn_i.
REQ-010 SHALL have port btn_level_o, output, 1, debounced button level.
REQ-011 SHALL have port press_cnt_o, output, 8, count of debounced presses.
REQ-012 SHALL have port overflow_o, output, 1, sticky flag: at least one press was dropped.

Function
REQ-013 SHALL synchronize btn_i through a 2-flop synchronizer before any use.
REQ-014 SHALL run a debounce counter that increments while the synchronized input differs from btn_level_o and clears to 0 on any cycle where they match.
REQ-015 SHALL toggle btn_level_o and clear the counter on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-016 SHALL make btn_level_o rise exactly DEBOUNCE_CYCLES+2 clock edges after btn_i goes high and stays high (2 sync + debounce).
REQ-017 SHALL define a press event as a 0->1 transition of btn_level_o, one-cycle internal pulse; 1->0 transitions generate no event.
REQ-018 SHALL increment press_cnt_o by 1 on every press event regardless of FSM state or irq_en_i; 255 wraps to 0.
REQ-019 SHALL implement FSM states IDLE, PEND, HOLDOFF.
REQ-020 SHALL, in IDLE, on press event with irq_en_i=1, go to PEND with irq_req_o=1 from the next edge (one cycle after btn_level_o rises).
REQ-021 SHALL, in IDLE, silently ignore press events with irq_en_i=0 (no overflow) and ignore irq_ack_i.
REQ-022 SHALL, in PEND, hold irq_req_o=1 until irq_ack_i=1 is sampled, then go to HOLDOFF, load holdoff counter with HOLDOFF_CYCLES-1, and drop irq_req_o on that same edge.
REQ-023 SHALL, in PEND with irq_en_i=0 and irq_ack_i=0, return to IDLE and drop irq_req_o on that edge; ack has priority when both occur.
REQ-024 SHALL, in HOLDOFF, decrement the counter each cycle and go to IDLE on the edge after it reads 0 (HOLDOFF_CYCLES cycles in HOLDOFF total); irq_ack_i ignored.
REQ-025 SHALL set overflow_o on any press event occurring in PEND or HOLDOFF; such presses never produce an extra interrupt.
REQ-026 SHALL clear overflow_o on ovf_clr_i=1; simultaneous set and clear leaves overflow_o=1.
REQ-027 SHALL drive all outputs directly from flops (no combinational input-to-output paths).

Reset
REQ-028 SHALL, on arst_n_i=0, asynchronously force: synchronizer flops 0, debounce counter 0, btn_level_o 0, FSM IDLE, holdoff counter 0, irq_req_o 0, press_cnt_o 0, overflow_o 0.
REQ-029 SHALL, on reset assertion mid-PEND or mid-HOLDOFF, abandon the operation; after release the block starts in IDLE with no pending request.
REQ-030 SHALL, if btn_i is held high through reset release, register a press after DEBOUNCE_CYCLES+2 edges (released level is 0).

Verification (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8)
REQ-031 SHALL cover clean press: btn_i high, irq_en_i=1 -> btn_level_o=1 at edge 6, irq_req_o=1 at edge 7, press_cnt_o=1.
REQ-032 SHALL cover bounce: btn_i toggling every 3 cycles for 30 cycles then low -> btn_level_o stays 0, press_cnt_o=0, irq_req_o=0.
REQ-033 SHALL cover handshake and holdoff: ack pulse in PEND -> irq_req_o=0 same edge, FSM in HOLDOFF exactly 8 cycles, second press during holdoff -> no request, overflow_o=1, press_cnt_o=2.
REQ-034 SHALL cover disable: press with irq_en_i=0 -> press_cnt_o=1, irq_req_o=0, overflow_o=0; deassert irq_en_i while PEND -> irq_req_o=0 next edge.
REQ-035 SHALL cover counter wrap and clear: 256 presses -> press_cnt_o=0; ovf_clr_i coincident with overflowing press -> overflow_o=1.
REQ-036 SHALL cover reset mid-PEND: arst_n_i low while irq_req_o=1 -> all outputs 0 immediately, IDLE after release.
